// File: rtl/riscv_dm_pkg.sv
// riscv_dm_pkg
//   Shared DMI widths, request opcodes, response status codes and the
//   state type of the DMI target front-end.
package riscv_dm_pkg;

  localparam int DMI_ADDR_WIDTH = 7;
  localparam int DMI_DATA_WIDTH = 32;
  localparam int DMI_OP_WIDTH   = 2;

  // Request opcodes; value 3 is reserved and answered with a failure.
  typedef enum logic [DMI_OP_WIDTH-1:0] {
    NOP = 2'd0,
    RD  = 2'd1,
    WR  = 2'd2
  } dmi_req_op_t;

  // Response status codes.
  localparam logic [DMI_OP_WIDTH-1:0] RD_OP_SUCCESS = 2'd0;
  localparam logic [DMI_OP_WIDTH-1:0] RD_OP_FAILED  = 2'd2;
  localparam logic [DMI_OP_WIDTH-1:0] RD_OP_BUSY    = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dmi_target_state_t;

endpackage

// File: rtl/riscv_dmi_target.sv
// riscv_dmi_target
//   DMI target front-end of the Debug Module. Accepts one DMI request at a
//   time, performs a single register-bank access for reads/writes and
//   returns a DMI response (data + status).
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   IDLE   | ready for a request (req_ready_o=1)
//   ACCESS | register-bank access in flight (reg_valid_o=1)
//   RESP   | response presented, waiting for resp_ready_i
//
// Ports:
//   clk_i, rst_i              clock, async active-high reset
//   req_valid_i/req_ready_o   DMI request handshake
//   req_addr_i/data_i/op_i    DMI request fields
//   resp_valid_o/resp_ready_i DMI response handshake
//   resp_data_o/resp_op_o     DMI response data and status
//   reg_valid_o/we/addr/wdata register-bank access request
//   reg_done_i/rdata_i/err_i  register-bank single-cycle completion
//
// Optional feature: define RISCV_DMI_TARGET_TIMEOUT_EN to bound the ACCESS
// state to TIMEOUT_CYCLES cycles; expiry yields a failed response.
module riscv_dmi_target
  import riscv_dm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [DMI_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DMI_DATA_WIDTH-1:0] req_data_i,
  input  logic [DMI_OP_WIDTH-1:0]   req_op_i,
  output logic                      resp_valid_o,
  input  logic                      resp_ready_i,
  output logic [DMI_DATA_WIDTH-1:0] resp_data_o,
  output logic [DMI_OP_WIDTH-1:0]   resp_op_o,
  output logic                      reg_valid_o,
  output logic                      reg_we_o,
  output logic [DMI_ADDR_WIDTH-1:0] reg_addr_o,
  output logic [DMI_DATA_WIDTH-1:0] reg_wdata_o,
  input  logic                      reg_done_i,
  input  logic [DMI_DATA_WIDTH-1:0] reg_rdata_i,
  input  logic                      reg_err_i
);

  dmi_target_state_t state;

`ifdef RISCV_DMI_TARGET_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt;
`else
  // Parameter kept for interface compatibility with the timeout build.
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
`endif

  // All outputs are registered so req_ready_o/reg_valid_o never depend
  // combinationally on an input.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      req_ready_o  <= 1'b1;
      resp_valid_o <= 1'b0;
      resp_data_o  <= '0;
      resp_op_o    <= RD_OP_SUCCESS;
      reg_valid_o  <= 1'b0;
      reg_we_o     <= 1'b0;
      reg_addr_o   <= '0;
      reg_wdata_o  <= '0;
`ifdef RISCV_DMI_TARGET_TIMEOUT_EN
      tmo_cnt      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            req_ready_o <= 1'b0;
            reg_addr_o  <= req_addr_i;
            reg_wdata_o <= req_data_i;
            reg_we_o    <= (req_op_i == WR);
            resp_data_o <= '0;
            if (req_op_i == RD || req_op_i == WR) begin
              state       <= ACCESS;
              reg_valid_o <= 1'b1;
`ifdef RISCV_DMI_TARGET_TIMEOUT_EN
              tmo_cnt     <= '0;
`endif
            end else begin
              // Nop succeeds, reserved opcode fails; neither touches the bank.
              state        <= RESP;
              resp_valid_o <= 1'b1;
              resp_op_o    <= (req_op_i == NOP) ? RD_OP_SUCCESS : RD_OP_FAILED;
            end
          end
        end

        ACCESS: begin
          if (reg_done_i) begin
            state        <= RESP;
            reg_valid_o  <= 1'b0;
            resp_valid_o <= 1'b1;
            resp_op_o    <= reg_err_i ? RD_OP_FAILED : RD_OP_SUCCESS;
            resp_data_o  <= (reg_we_o || reg_err_i) ? '0 : reg_rdata_i;
          end
`ifdef RISCV_DMI_TARGET_TIMEOUT_EN
          // Completion in the expiry cycle wins over the timeout.
          else if (tmo_cnt == TMO_LAST) begin
            state        <= RESP;
            reg_valid_o  <= 1'b0;
            resp_valid_o <= 1'b1;
            resp_op_o    <= RD_OP_FAILED;
            resp_data_o  <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end

        RESP: begin
          if (resp_ready_i) begin
            state        <= IDLE;
            resp_valid_o <= 1'b0;
            req_ready_o  <= 1'b1;
          end
        end

        default: begin
          state        <= IDLE;
          req_ready_o  <= 1'b1;
          resp_valid_o <= 1'b0;
          reg_valid_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_dmi_target.sv
// tb_riscv_dmi_target
//   Self-checking bench for riscv_dmi_target: table of request vectors with
//   expected responses/latencies, a response scoreboard queue, a simple
//   register-bank responder, and hand sequences for stall, reset-mid-access,
//   back-to-back and (with RISCV_DMI_TARGET_TIMEOUT_EN) timeout behaviour.
module tb_riscv_dmi_target;
  import riscv_dm_pkg::*;

  logic                      clk_i = 1'b0;
  logic                      rst_i;
  logic                      req_valid_i;
  logic                      req_ready_o;
  logic [DMI_ADDR_WIDTH-1:0] req_addr_i;
  logic [DMI_DATA_WIDTH-1:0] req_data_i;
  logic [DMI_OP_WIDTH-1:0]   req_op_i;
  logic                      resp_valid_o;
  logic                      resp_ready_i;
  logic [DMI_DATA_WIDTH-1:0] resp_data_o;
  logic [DMI_OP_WIDTH-1:0]   resp_op_o;
  logic                      reg_valid_o;
  logic                      reg_we_o;
  logic [DMI_ADDR_WIDTH-1:0] reg_addr_o;
  logic [DMI_DATA_WIDTH-1:0] reg_wdata_o;
  logic                      reg_done_i;
  logic [DMI_DATA_WIDTH-1:0] reg_rdata_i;
  logic                      reg_err_i;

  riscv_dmi_target #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr_i),
    .req_data_i   (req_data_i),
    .req_op_i     (req_op_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_data_o  (resp_data_o),
    .resp_op_o    (resp_op_o),
    .reg_valid_o  (reg_valid_o),
    .reg_we_o     (reg_we_o),
    .reg_addr_o   (reg_addr_o),
    .reg_wdata_o  (reg_wdata_o),
    .reg_done_i   (reg_done_i),
    .reg_rdata_i  (reg_rdata_i),
    .reg_err_i    (reg_err_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  op;
    logic [6:0]  addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] exp_data;
    logic [1:0]  exp_op;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  op;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[7];

  int checks = 0;
  int errors = 0;

  // register-bank responder state
  bit          bank_en = 1'b1;
  int          bank_delay = 0;
  logic [31:0] bank_rdata = '0;
  logic        bank_err = 1'b0;
  int          bank_cnt = 0;

  // expected register-bank request fields of the transaction in flight
  logic        cur_we = 1'b0;
  logic [6:0]  cur_addr = '0;
  logic [31:0] cur_wdata = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Observes the cycle about to close, advances one clock, then drives the
  // bank responder for the new cycle.
  task automatic tick();
    exp_t e;
    if (reg_valid_o) begin
      chk("reg_we", 32'(reg_we_o), 32'(cur_we));
      chk("reg_addr", 32'(reg_addr_o), 32'(cur_addr));
      chk("reg_wdata", reg_wdata_o, cur_wdata);
    end
    if (resp_valid_o && resp_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'(resp_valid_o), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_data", resp_data_o, e.data);
        chk("resp_op", 32'(resp_op_o), 32'(e.op));
      end
    end
    @(posedge clk_i);
    #1;
    reg_done_i  = 1'b0;
    reg_err_i   = 1'b0;
    reg_rdata_i = '0;
    if (!reg_valid_o) begin
      bank_cnt = 0;
    end else if (bank_en) begin
      if (bank_cnt == bank_delay) begin
        reg_done_i  = 1'b1;
        reg_err_i   = bank_err;
        reg_rdata_i = bank_rdata;
      end
      bank_cnt++;
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                      input logic [31:0] ed, input logic [1:0] eo);
    int n = 0;
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_addr_i  = addr;
    req_data_i  = data;
    while (!req_ready_o && n < 50) begin
      tick();
      n++;
    end
    if (!req_ready_o) begin
      chk("req_ready_wait", 32'(req_ready_o), 32'd1);
      req_valid_i = 1'b0;
      return;
    end
    exp_q.push_back('{data: ed, op: eo});
    cur_we    = (op == 2'd2);
    cur_addr  = addr;
    cur_wdata = data;
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int lat  = 0;
    int vcyc = 0;
    bank_delay = v.delay;
    bank_rdata = v.rdata;
    bank_err   = v.err;
    send(v.op, v.addr, v.wdata, v.exp_data, v.exp_op);
    while (!resp_valid_o && lat < 40) begin
      if (reg_valid_o) vcyc++;
      tick();
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'(v.exp_lat));
    chk({nm, "_reg_valid_cycles"}, 32'(vcyc), 32'(v.exp_lat));
    chk({nm, "_req_ready_low"}, 32'(req_ready_o), 32'd0);
    tick();
    chk({nm, "_req_ready_back"}, 32'(req_ready_o), 32'd1);
  endtask

  initial begin
    int nacc;
    int acc_cyc[3];
    int n;

    vecs[0] = '{2'd1, 7'h11, 32'h0000_0000, 0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 2'd0, 1};
    vecs[1] = '{2'd2, 7'h04, 32'h1234_5678, 3, 32'hAAAA_5555, 1'b1, 32'h0000_0000, 2'd2, 4};
    vecs[2] = '{2'd0, 7'h10, 32'h0000_0001, 0, 32'h5555_AAAA, 1'b0, 32'h0000_0000, 2'd0, 0};
    vecs[3] = '{2'd3, 7'h12, 32'h0000_0002, 0, 32'h5555_AAAA, 1'b0, 32'h0000_0000, 2'd2, 0};
    vecs[4] = '{2'd1, 7'h7F, 32'h0000_0000, 2, 32'hCAFE_F00D, 1'b1, 32'h0000_0000, 2'd2, 3};
    vecs[5] = '{2'd2, 7'h20, 32'hA5A5_0F0F, 1, 32'h1111_2222, 1'b0, 32'h0000_0000, 2'd0, 2};
    vecs[6] = '{2'd1, 7'h00, 32'hFFFF_FFFF, 3, 32'h0000_0001, 1'b0, 32'h0000_0001, 2'd0, 4};

    rst_i        = 1'b1;
    req_valid_i  = 1'b0;
    req_addr_i   = '0;
    req_data_i   = '0;
    req_op_i     = '0;
    resp_ready_i = 1'b1;
    reg_done_i   = 1'b0;
    reg_rdata_i  = '0;
    reg_err_i    = 1'b0;

    #3;
    chk("rst_req_ready", 32'(req_ready_o), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    chk("rst_resp_data", resp_data_o, 32'd0);
    chk("rst_resp_op", 32'(resp_op_o), 32'd0);
    chk("rst_reg_valid", 32'(reg_valid_o), 32'd0);
    chk("rst_reg_we", 32'(reg_we_o), 32'd0);
    chk("rst_reg_addr", 32'(reg_addr_o), 32'd0);
    chk("rst_reg_wdata", reg_wdata_o, 32'd0);
    tick();
    tick();
    rst_i = 1'b0;
    tick();

    // table of single transactions, zero-stall consumer
    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // nop then reserved op with the consumer stalled for 5 cycles
    resp_ready_i = 1'b0;
    send(2'd0, 7'h01, 32'h0, 32'h0, 2'd0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_nop_valid", 32'(resp_valid_o), 32'd1);
      chk("stall_nop_op", 32'(resp_op_o), 32'd0);
      chk("stall_nop_data", resp_data_o, 32'd0);
      chk("stall_nop_req_ready", 32'(req_ready_o), 32'd0);
      chk("stall_nop_reg_valid", 32'(reg_valid_o), 32'd0);
      tick();
    end
    resp_ready_i = 1'b1;
    tick();
    resp_ready_i = 1'b0;
    send(2'd3, 7'h15, 32'hFFFF_FFFF, 32'h0, 2'd2);
    for (int i = 0; i < 5; i++) begin
      chk("stall_resv_valid", 32'(resp_valid_o), 32'd1);
      chk("stall_resv_op", 32'(resp_op_o), 32'd2);
      chk("stall_resv_data", resp_data_o, 32'd0);
      chk("stall_resv_req_ready", 32'(req_ready_o), 32'd0);
      chk("stall_resv_reg_valid", 32'(reg_valid_o), 32'd0);
      tick();
    end
    resp_ready_i = 1'b1;
    tick();
    chk("stall_done_req_ready", 32'(req_ready_o), 32'd1);

`ifdef RISCV_DMI_TARGET_TIMEOUT_EN
    // bank never answers: access is abandoned after 4 cycles
    bank_en = 1'b0;
    run_vec('{2'd1, 7'h05, 32'h0, 0, 32'h0, 1'b0, 32'h0, 2'd2, 4}, "timeout");
    bank_en = 1'b1;
    // done in the 4th (expiry) cycle is a normal completion
    run_vec('{2'd1, 7'h06, 32'h0, 3, 32'h5A5A_5A5A, 1'b0, 32'h5A5A_5A5A, 2'd0, 4}, "tmo_edge");
`endif

    // reset in the middle of an access drops the request
    bank_en = 1'b0;
    send(2'd1, 7'h22, 32'h0, 32'h0, 2'd0);
    tick();
    chk("pre_rst_reg_valid", 32'(reg_valid_o), 32'd1);
    #3;
    rst_i = 1'b1;
    #1;
    chk("mid_rst_reg_valid", 32'(reg_valid_o), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready_o), 32'd1);
    chk("mid_rst_resp_valid", 32'(resp_valid_o), 32'd0);
    chk("mid_rst_reg_addr", 32'(reg_addr_o), 32'd0);
    exp_q.delete();
    tick();
    tick();
    rst_i   = 1'b0;
    bank_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("post_rst_no_resp", 32'(resp_valid_o), 32'd0);
      tick();
    end
    run_vec('{2'd1, 7'h33, 32'h0, 1, 32'h0BAD_CAFE, 1'b0, 32'h0BAD_CAFE, 2'd0, 2}, "post_rst");

    // back-to-back reads with req_valid_i held high
    bank_delay = 0;
    bank_rdata = 32'h0BAD_F00D;
    bank_err   = 1'b0;
    req_valid_i = 1'b1;
    req_op_i    = 2'd1;
    req_addr_i  = 7'h30;
    req_data_i  = 32'h0000_0077;
    nacc = 0;
    for (int c = 0; c < 30 && nacc < 3; c++) begin
      if (req_ready_o) begin
        acc_cyc[nacc] = c;
        exp_q.push_back('{data: 32'h0BAD_F00D, op: 2'd0});
        cur_we    = 1'b0;
        cur_addr  = req_addr_i;
        cur_wdata = req_data_i;
        nacc++;
      end
      tick();
      req_addr_i = 7'h30 + 7'(nacc);
    end
    req_valid_i = 1'b0;
    chk("b2b_accepts", 32'(nacc), 32'd3);
    if (nacc == 3) begin
      chk("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
      chk("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
